sdcard_arbiter: RTL and testbench
=================================

# sdcard_arbiter

Round-robin arbiter that shares the single physical SD card between several storage and tape controllers, each of which drives its own SD-SPI engine. It owns the `sdreq`/`sdack` handshake seen by every requester and multiplexes the winning requester's SPI pins onto the card. It sits at board level, between the peripheral controllers and the card socket, and is clocked by the common bus clock.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `GAP`, default 4: idle cycles inserted between grants, with CS high; legal range 1..255.

Ports:
- `clk_p`, in, 1: bus clock; all logic on the rising edge.
- `sys_init`, in, 1: reset, synchronous, active-high.
- `sdreq`, in, N_REQ: per-requester access request, level.
- `sdack`, out, N_REQ: per-requester grant, one-hot or zero, registered.
- `req_cs`, in, N_REQ: per-requester SPI chip select, active low.
- `req_mosi`, in, N_REQ: per-requester SPI MOSI.
- `req_sclk`, in, N_REQ: per-requester SPI clock.
- `req_miso`, out, N_REQ: card MISO, broadcast to all requesters.
- `sdcard_cs`, out, 1: physical card CS.
- `sdcard_mosi`, out, 1: physical card MOSI.
- `sdcard_sclk`, out, 1: physical card SCLK.
- `sdcard_miso`, in, 1: physical card MISO.
- `busy`, out, 1: grant active (state GRANT).
- `owner`, out, 3: index of the current or last granted requester.

## Operation
- States:
  - ARB_IDLE: no grant.
  - ARB_GRANT: exactly one `sdack` bit high.
  - ARB_RELEASE: gap countdown.
- ARB_IDLE:
  - If `sdreq` is nonzero, select the first set bit scanning upward from `owner`+1, modulo N_REQ (round robin).
  - Set `owner` to that index and raise `sdack[owner]`, then go to GRANT.
  - If `sdreq` is zero, stay in IDLE.
- ARB_GRANT:
  - Hold the grant while `sdreq[owner]`=1; grants are never revoked by other requests.
  - When `sdreq[owner]`=0: clear `sdack`, load the gap counter with GAP-1, go to RELEASE.
- ARB_RELEASE:
  - Decrement the counter each cycle.
  - When the counter is 0, go to IDLE; requests are ignored during RELEASE.
- Pin mux:
  - In GRANT: `sdcard_cs/mosi/sclk` = `req_cs/mosi/sclk[owner]`.
  - Otherwise: CS=1, MOSI=1, SCLK=0.
  - Mux select is the registered `owner` gated by registered state, so it is glitch-free relative to `clk_p`.
- `req_miso` = {N_REQ{`sdcard_miso`}} at all times. Non-owners must ignore it.
- A requester that drops `sdreq` before being granted is simply not selected.
- A requester that drops `sdreq` in the same cycle its ack rises still receives one GRANT cycle, then is released normally.

## Timing
- Reset values:
  - state=IDLE, `sdack`=0, `owner`=N_REQ-1 (so requester 0 wins first), `busy`=0, gap counter=0.
  - Card pins: CS=1, MOSI=1, SCLK=0.
- `sys_init` mid-transfer: at the next edge, all of the reset values above apply and the card is deselected immediately. Requesters are reset by the same `sys_init`.
- Grant latency:
  - `sdreq[i]` sampled high in IDLE at edge t -> `sdack[i]`=1 and pins switched after edge t.
  - Minimum 1 cycle.
- Release latency:
  - `sdreq[owner]` sampled low at edge t -> `sdack`=0 and pins idle after edge t.
  - IDLE is entered after edge t+GAP.
  - The earliest next grant appears after edge t+GAP+1.
- Arbitration is evaluated only in IDLE. Simultaneous requests are resolved by the round-robin pointer in that single cycle.
- Fairness: with all N_REQ requesting continuously, each is served once per N_REQ grants.
- `owner` is incremented modulo N_REQ. The width is fixed at 3 bits; unused codes are never produced.

## Structure
- Shared package holds:
  - state encoding `ARB_IDLE`=2'd0, `ARB_GRANT`=2'd1, `ARB_RELEASE`=2'd2;
  - idle pin-level constants `SD_CS_IDLE`=1, `SD_MOSI_IDLE`=1, `SD_SCLK_IDLE`=0.
- One sub-module, `rr_pick`:
  - combinational; takes the request vector and the pointer;
  - returns the next owner index and a found flag.
- Parameter checks live in the top module: `N_REQ` in 2..8, `GAP` in 1..255.

## Test plan
- Reset: hold `sys_init` 3 cycles with `sdreq`=4'b1111 -> `sdack`=0, `sdcard_cs`=1, `sdcard_sclk`=0, `busy`=0. After release -> `sdack`=4'b0001 one cycle later.
- Single requester: raise `sdreq[2]` at cycle 10 -> `sdack`=4'b0100 at 11. Drop it at 20 -> `sdack`=0 at 21, with GAP=4. Re-raise at 21 -> ack at 26, not earlier.
- Round robin: `sdreq`=4'b1111 held, each owner drops its request 5 cycles after its ack and re-raises 1 cycle later -> grant order 0,1,2,3,0,1.
- Pin mux: during grant to requester 1, toggle `req_sclk[1]` and `req_sclk[0]` -> `sdcard_sclk` follows only [1]. During RELEASE -> `sdcard_sclk`=0 and `sdcard_cs`=1.
- Reset mid-grant: assert `sys_init` while `owner`=3 is busy -> next cycle `sdack`=0 and pins idle. First grant after reset goes to the lowest active requester.
- Early drop: pulse `sdreq[1]` for 1 cycle in IDLE -> `sdack[1]` is high for exactly 1 cycle, then RELEASE lasts GAP cycles.

Source files
------------

// File: rtl/sdcard_arbiter_pkg.sv
// Shared definitions for the SD card arbiter: FSM state codes, idle card pin
// levels and a small bit-select helper.
package sdcard_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT   = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;

    localparam logic SD_CS_IDLE   = 1'b1;
    localparam logic SD_MOSI_IDLE = 1'b1;
    localparam logic SD_SCLK_IDLE = 1'b0;

    // Select one bit of a requester vector padded out to the 3-bit index range.
    function automatic logic sel8(input logic [7:0] vec, input logic [2:0] idx);
        return vec[idx];
    endfunction

endpackage

// File: rtl/sdcard_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from ptr+1, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       idx,
    output logic             found
);

    logic [7:0] req_ext_s;

    assign req_ext_s = 8'(req);

    // Scan candidates in priority order; the first hit wins.
    always_comb begin
        logic [2:0] cand;
        idx   = 3'd0;
        found = 1'b0;
        cand  = 3'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = 3'((int'(ptr) + k) % N_REQ);
            if (!found && req_ext_s[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/sdcard_arbiter.sv
// Round-robin owner of the shared SD card: runs the sdreq/sdack handshake and
// steers the granted requester's SPI pins onto the card socket.
module sdcard_arbiter
    import sdcard_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GAP   = 4
) (
    input  logic             clk_p,
    input  logic             sys_init,
    input  logic [N_REQ-1:0] sdreq,
    output logic [N_REQ-1:0] sdack,
    input  logic [N_REQ-1:0] req_cs,
    input  logic [N_REQ-1:0] req_mosi,
    input  logic [N_REQ-1:0] req_sclk,
    output logic [N_REQ-1:0] req_miso,
    output logic             sdcard_cs,
    output logic             sdcard_mosi,
    output logic             sdcard_sclk,
    input  logic             sdcard_miso,
    output logic             busy,
    output logic [2:0]       owner
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("sdcard_arbiter: N_REQ must be in 2..8");
    end
    if (GAP < 1 || GAP > 255) begin : g_bad_gap
        $error("sdcard_arbiter: GAP must be in 1..255");
    end

    logic [1:0]       state_r;
    logic [2:0]       owner_r;
    logic [7:0]       gap_r;
    logic [N_REQ-1:0] sdack_r;
    logic             busy_r;
    logic [2:0]       pick_idx_s;
    logic             pick_found_s;
    logic [7:0]       sdreq_ext_s;
    logic [7:0]       cs_ext_s;
    logic [7:0]       mosi_ext_s;
    logic [7:0]       sclk_ext_s;
    logic             cs_s;
    logic             mosi_s;
    logic             sclk_s;

    assign sdreq_ext_s = 8'(sdreq);
    assign cs_ext_s    = 8'(req_cs);
    assign mosi_ext_s  = 8'(req_mosi);
    assign sclk_ext_s  = 8'(req_sclk);

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (sdreq),
        .ptr   (owner_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Grant FSM; owner resets to the last index so requester 0 wins first.
    always_ff @(posedge clk_p) begin
        if (sys_init) begin
            state_r <= ARB_IDLE;
            owner_r <= 3'(N_REQ - 1);
            gap_r   <= 8'd0;
            sdack_r <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_found_s) begin
                        owner_r <= pick_idx_s;
                        state_r <= ARB_GRANT;
                        busy_r  <= 1'b1;
                        for (int i = 0; i < N_REQ; i++) begin
                            sdack_r[i] <= (pick_idx_s == 3'(i));
                        end
                    end
                end
                ARB_GRANT: begin
                    if (!sel8(sdreq_ext_s, owner_r)) begin
                        sdack_r <= {N_REQ{1'b0}};
                        gap_r   <= 8'(GAP - 1);
                        state_r <= ARB_RELEASE;
                        busy_r  <= 1'b0;
                    end
                end
                ARB_RELEASE: begin
                    if (gap_r == 8'd0) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        gap_r <= gap_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                    sdack_r <= {N_REQ{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Card pin mux: select comes only from registers, so it never glitches mid-cycle.
    always_comb begin
        cs_s   = SD_CS_IDLE;
        mosi_s = SD_MOSI_IDLE;
        sclk_s = SD_SCLK_IDLE;
        if (state_r == ARB_GRANT) begin
            cs_s   = sel8(cs_ext_s, owner_r);
            mosi_s = sel8(mosi_ext_s, owner_r);
            sclk_s = sel8(sclk_ext_s, owner_r);
        end else begin
            cs_s   = SD_CS_IDLE;
            mosi_s = SD_MOSI_IDLE;
            sclk_s = SD_SCLK_IDLE;
        end
    end

    assign sdcard_cs   = cs_s;
    assign sdcard_mosi = mosi_s;
    assign sdcard_sclk = sclk_s;
    assign req_miso    = {N_REQ{sdcard_miso}};
    assign sdack       = sdack_r;
    assign busy        = busy_r;
    assign owner       = owner_r;

endmodule

// File: tb/tb_sdcard_arbiter.sv
// Directed and randomized bench for sdcard_arbiter against a holder/cooldown
// reference model of the arbitration rules.
module tb_sdcard_arbiter;

    localparam int N = 4;
    localparam int G = 4;

    logic       clk_p = 1'b0;
    logic       sys_init;
    logic [3:0] sdreq;
    logic [3:0] sdack;
    logic [3:0] req_cs;
    logic [3:0] req_mosi;
    logic [3:0] req_sclk;
    logic [3:0] req_miso;
    logic       sdcard_cs;
    logic       sdcard_mosi;
    logic       sdcard_sclk;
    logic       sdcard_miso;
    logic       busy;
    logic [2:0] owner;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who holds the card, idle cycles still owed, last winner.
    int m_holder = -1;
    int m_cool   = 0;
    int m_last   = N - 1;

    sdcard_arbiter #(.N_REQ(N), .GAP(G)) dut (
        .clk_p       (clk_p),
        .sys_init    (sys_init),
        .sdreq       (sdreq),
        .sdack       (sdack),
        .req_cs      (req_cs),
        .req_mosi    (req_mosi),
        .req_sclk    (req_sclk),
        .req_miso    (req_miso),
        .sdcard_cs   (sdcard_cs),
        .sdcard_mosi (sdcard_mosi),
        .sdcard_sclk (sdcard_sclk),
        .sdcard_miso (sdcard_miso),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk_p = ~clk_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_update();
        if (sys_init) begin
            m_holder = -1;
            m_cool   = 0;
            m_last   = N - 1;
        end else if (m_holder >= 0) begin
            if (!sdreq[m_holder]) begin
                m_holder = -1;
                m_cool   = G;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (sdreq[c]) begin
                    m_holder = c;
                    m_last   = c;
                    break;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_ack;
        logic [2:0] exp_pins;
        exp_ack  = 4'b0000;
        exp_pins = 3'b110;
        if (m_holder >= 0) begin
            exp_ack  = 4'b0001 << m_holder;
            exp_pins = {req_cs[m_holder], req_mosi[m_holder], req_sclk[m_holder]};
        end
        chk("sdack", 32'(sdack), 32'(exp_ack));
        chk("busy", 32'(busy), 32'(m_holder >= 0));
        chk("owner", 32'(owner), 32'(m_last));
        chk("card_pins", 32'({sdcard_cs, sdcard_mosi, sdcard_sclk}), 32'(exp_pins));
        chk("req_miso", 32'(req_miso), 32'({4{sdcard_miso}}));
    endtask

    task automatic step();
        @(posedge clk_p);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        int cnt;
        int hi;
        int held;
        int dropped;
        int order[$];
        int exp_rr[6];
        logic [3:0] prev;

        exp_rr      = '{0, 1, 2, 3, 0, 1};
        sys_init    = 1'b1;
        sdreq       = 4'b1111;
        req_cs      = 4'b1111;
        req_mosi    = 4'b0000;
        req_sclk    = 4'b1111;
        sdcard_miso = 1'b1;

        // Reset held with every requester asking.
        repeat (3) step();
        chk("rst_sdack", 32'(sdack), 32'h0);
        chk("rst_cs", 32'(sdcard_cs), 32'h1);
        chk("rst_sclk", 32'(sdcard_sclk), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        sys_init = 1'b0;
        step();
        chk("first_grant", 32'(sdack), 32'h1);

        // Single requester, drop and immediate re-raise.
        sdreq = 4'b0000;
        repeat (G + 3) step();
        sdreq = 4'b0100;
        step();
        chk("single_grant", 32'(sdack), 32'h4);
        repeat (8) step();
        sdreq = 4'b0000;
        step();
        chk("single_drop", 32'(sdack), 32'h0);
        sdreq = 4'b0100;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!sdack[2] && cnt < 20);
        chk("regrant_latency", 32'(cnt), 32'(G + 1));

        // Pin mux with requester 1 owning the card.
        sdreq = 4'b0000;
        repeat (G + 2) step();
        req_cs = 4'b0000;
        sdreq  = 4'b0010;
        step();
        chk("mux_owner", 32'(owner), 32'h1);
        for (int i = 0; i < 6; i++) begin
            req_sclk = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            #1;
            chk("mux_sclk", 32'(sdcard_sclk), 32'(req_sclk[1]));
            step();
        end
        sdreq = 4'b0000;
        step();
        req_sclk = 4'b1111;
        #1;
        chk("release_sclk", 32'(sdcard_sclk), 32'h0);
        chk("release_cs", 32'(sdcard_cs), 32'h1);
        step();

        // Round robin with everyone requesting.
        sys_init = 1'b1;
        step();
        sys_init = 1'b0;
        sdreq    = 4'b1111;
        prev     = 4'b0000;
        held     = 0;
        dropped  = -1;
        for (int cyc = 0; cyc < 200 && order.size() < 6; cyc++) begin
            if (dropped >= 0) begin
                sdreq[dropped] = 1'b1;
                dropped = -1;
            end
            if (sdack != 4'b0000) begin
                if (prev == 4'b0000) order.push_back(int'(owner));
                held++;
                if (held == 5) begin
                    dropped = int'(owner);
                    sdreq[owner] = 1'b0;
                    held = 0;
                end
            end else begin
                held = 0;
            end
            prev = sdack;
            step();
        end
        chk("rr_count", 32'(order.size()), 32'h6);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            chk("rr_order", 32'(order[i]), 32'(exp_rr[i]));
        end

        // Reset while requester 3 owns the card.
        sys_init = 1'b1;
        step();
        sys_init = 1'b0;
        sdreq    = 4'b1000;
        step();
        chk("mid_owner3", 32'(sdack), 32'h8);
        step();
        sys_init = 1'b1;
        step();
        chk("midrst_sdack", 32'(sdack), 32'h0);
        chk("midrst_cs", 32'(sdcard_cs), 32'h1);
        sys_init = 1'b0;
        sdreq    = 4'b1010;
        step();
        chk("post_rst_grant", 32'(sdack), 32'h2);

        // One-cycle request pulse.
        sdreq = 4'b0000;
        repeat (G + 3) step();
        sdreq = 4'b0010;
        step();
        sdreq = 4'b0000;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (sdack[1]) hi++;
            step();
        end
        chk("pulse_ack_width", 32'(hi), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            sdreq       = sdreq ^ 4'($urandom & $urandom);
            req_cs      = 4'($urandom);
            req_mosi    = 4'($urandom);
            req_sclk    = 4'($urandom);
            sdcard_miso = 1'($urandom);
            sys_init    = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
